// File: rtl/pipeline_hazard_ctrl.sv
//----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a classic five-stage in-order
// pipeline (IF, ID, EX, MEM, WB). The controller does the following:
//   - tracks which stages hold a real instruction,
//   - detects data hazards between the ID sources and older destinations,
//   - selects EX operand forwarding,
//   - applies control-flow redirects resolved in MEM,
//   - drains the pipeline after a halt instruction,
//   - guards the run with a cycle-limit watchdog.
//
// Build option (macro HAZARD_FORWARDING_EN):
//   defined   : EX operands are forwarded from MEM/WB. Only a load in EX
//               whose destination feeds the ID instruction stalls, for
//               one cycle.
//   undefined : no forwarding (fwd_a = fwd_b = 00). ID stalls while any
//               valid, writing EX/MEM/WB instruction targets one of its
//               sources.
//
// Parameters
//   REG_AW       register-address width
//   CNT_W        cycle-counter width
//   CYCLE_LIMIT  cycle count at which the run is declared timed out
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   id_rs, id_rt                  ID source registers
//   id_uses_rs, id_uses_rt        ID instruction actually reads rs / rt
//   id_halt                       ID instruction is the halt word
//   ex_rs, ex_rt                  EX source registers (forwarding targets)
//   ex_regwrite, ex_memread       EX control bits
//   ex_dst, mem_dst, wb_dst       destination registers per stage
//   mem_regwrite, wb_regwrite     MEM / WB write enables
//   mem_redirect                  taken branch or jump resolved in MEM
//   pc_en, if_id_en               PC and IF/ID load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                  insert a bubble at the next edge
//   fwd_a, fwd_b                  00 regfile, 01 EX/MEM result, 10 WB value
//   stage_valid                   {WB, MEM, EX, ID} valid bits
//   state                         0 RUN, 1 DRAIN, 2 DONE, 3 TIMEOUT
//   cycle_count                   cycles spent in RUN/DRAIN since reset
//   halted, timeout               terminal-state flags
//----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              mem_redirect,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [3:0]        stage_valid,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              timeout
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(CYCLE_LIMIT);

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic dst_hits_id(
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              use_rs,
        input logic              use_rt
    );
        logic hit;
        if (dst != REG_ZERO) begin
            hit = (use_rs && (dst == rs)) || (use_rt && (dst == rt));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // The youngest producer (MEM) wins over WB when both target the source.
    function automatic logic [1:0] fwd_select(
        input logic [REG_AW-1:0] src,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mdst,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wdst
    );
        logic [1:0] sel;
        if (mem_ok && (mdst != REG_ZERO) && (mdst == src)) begin
            sel = 2'b01;
        end else if (wb_ok && (wdst != REG_ZERO) && (wdst == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Registered state
    state_t             state_r;
    logic [3:0]         valid_r;     // {WB, MEM, EX, ID}
    logic [2:0]         marker_r;    // halt position {WB, MEM, EX}
    logic [CNT_W-1:0]   count_r;

    // Next-state values
    state_t             state_nom_s;
    state_t             state_s;
    logic [3:0]         valid_s;
    logic [2:0]         marker_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               running_s;
    logic               limit_hit_s;

    // Hazard / forwarding terms
    logic               id_v_s;
    logic               ex_v_s;
    logic               mem_v_s;
    logic               wb_v_s;
    logic               mem_fwd_ok_s;
    logic               wb_fwd_ok_s;
    logic               ex_hit_s;
    logic               hazard_s;
    logic               redirect_s;
    logic [1:0]         fwd_a_raw_s;
    logic [1:0]         fwd_b_raw_s;
    logic               unused_cfg_s;

    // Control outputs before the reset override
    logic               pc_en_s;
    logic               if_id_en_s;
    logic               if_id_flush_s;
    logic               id_ex_flush_s;
    logic               ex_mem_flush_s;
    logic [1:0]         fwd_a_s;
    logic [1:0]         fwd_b_s;

    assign id_v_s       = valid_r[0];
    assign ex_v_s       = valid_r[1];
    assign mem_v_s      = valid_r[2];
    assign wb_v_s       = valid_r[3];
    assign mem_fwd_ok_s = mem_v_s & mem_regwrite;
    assign wb_fwd_ok_s  = wb_v_s & wb_regwrite;
    assign ex_hit_s     = dst_hits_id(ex_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign redirect_s   = mem_v_s & mem_redirect;

`ifdef HAZARD_FORWARDING_EN
    // With forwarding, only a load result is too late for the next EX.
    assign hazard_s     = id_v_s & ex_v_s & ex_memread & ex_hit_s;
    assign fwd_a_raw_s  = fwd_select(ex_rs, mem_fwd_ok_s, mem_dst, wb_fwd_ok_s, wb_dst);
    assign fwd_b_raw_s  = fwd_select(ex_rt, mem_fwd_ok_s, mem_dst, wb_fwd_ok_s, wb_dst);
    assign unused_cfg_s = ex_regwrite;
`else
    logic mem_hit_s;
    logic wb_hit_s;
    assign mem_hit_s    = dst_hits_id(mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign wb_hit_s     = dst_hits_id(wb_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    // Without forwarding, ID waits until every pending writer has retired.
    assign hazard_s     = id_v_s & ((ex_v_s & ex_regwrite & ex_hit_s) |
                                    (mem_fwd_ok_s & mem_hit_s) |
                                    (wb_fwd_ok_s & wb_hit_s));
    assign fwd_a_raw_s  = 2'b00;
    assign fwd_b_raw_s  = 2'b00;
    assign unused_cfg_s = ^{ex_rs, ex_rt, ex_memread};
`endif

    assign running_s   = (state_r == RUN) || (state_r == DRAIN);
    assign count_inc_s = count_r + CNT_ONE;
    // The watchdog overrides any other transition taken in the same cycle.
    assign limit_hit_s = running_s && (count_inc_s >= CNT_LIMIT);
    assign state_s     = limit_hit_s ? TIMEOUT : state_nom_s;

    // Next-state, pipeline-valid bookkeeping and control outputs
    always_comb begin
        state_nom_s    = state_r;
        valid_s        = valid_r;
        marker_s       = marker_r;
        count_s        = count_r;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        fwd_a_s        = fwd_a_raw_s;
        fwd_b_s        = fwd_b_raw_s;
        case (state_r)
            RUN: begin
                count_s = count_inc_s;
                if (redirect_s) begin
                    // Redirect beats a load-use stall: everything younger
                    // than the branch is wrong-path.
                    if_id_flush_s  = 1'b1;
                    id_ex_flush_s  = 1'b1;
                    ex_mem_flush_s = 1'b1;
                    valid_s        = {mem_v_s, 3'b000};
                end else if (hazard_s) begin
                    // Hold PC and ID, send a bubble into EX.
                    pc_en_s       = 1'b0;
                    if_id_en_s    = 1'b0;
                    id_ex_flush_s = 1'b1;
                    valid_s       = {mem_v_s, ex_v_s, 1'b0, id_v_s};
                end else if (id_v_s && id_halt) begin
                    valid_s     = {mem_v_s, ex_v_s, id_v_s, 1'b1};
                    marker_s    = 3'b001;
                    state_nom_s = DRAIN;
                end else begin
                    valid_s = {mem_v_s, ex_v_s, id_v_s, 1'b1};
                end
            end
            DRAIN: begin
                count_s = count_inc_s;
                if (redirect_s && (marker_r[0] || marker_r[1])) begin
                    // The halt was fetched down a wrong path: drop it and resume.
                    if_id_flush_s  = 1'b1;
                    id_ex_flush_s  = 1'b1;
                    ex_mem_flush_s = 1'b1;
                    valid_s        = {mem_v_s, 3'b000};
                    marker_s       = 3'b000;
                    state_nom_s    = RUN;
                end else begin
                    pc_en_s       = 1'b0;
                    if_id_flush_s = 1'b1;
                    valid_s       = {mem_v_s, ex_v_s, id_v_s, 1'b0};
                    marker_s      = {marker_r[1:0], 1'b0};
                    if (marker_r[2]) begin
                        state_nom_s = DONE;
                    end else begin
                        state_nom_s = DRAIN;
                    end
                end
            end
            DONE, TIMEOUT: begin
                pc_en_s    = 1'b0;
                if_id_en_s = 1'b0;
                fwd_a_s    = 2'b00;
                fwd_b_s    = 2'b00;
            end
            default: begin
                state_nom_s = RUN;
                valid_s     = 4'b0000;
                marker_s    = 3'b000;
                count_s     = CNT_ZERO;
            end
        endcase
    end

    // State, valid, halt-marker and cycle-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            valid_r  <= 4'b0000;
            marker_r <= 3'b000;
            count_r  <= CNT_ZERO;
        end else begin
            state_r  <= state_s;
            valid_r  <= valid_s;
            marker_r <= marker_s;
            count_r  <= count_s;
        end
    end

    // While reset is asserted the front end keeps fetching and nothing is flushed.
    assign pc_en        = rst ? 1'b1  : pc_en_s;
    assign if_id_en     = rst ? 1'b1  : if_id_en_s;
    assign if_id_flush  = rst ? 1'b0  : if_id_flush_s;
    assign id_ex_flush  = rst ? 1'b0  : id_ex_flush_s;
    assign ex_mem_flush = rst ? 1'b0  : ex_mem_flush_s;
    assign fwd_a        = rst ? 2'b00 : fwd_a_s;
    assign fwd_b        = rst ? 2'b00 : fwd_b_s;

    assign stage_valid  = valid_r;
    assign state        = state_r;
    assign cycle_count  = count_r;
    assign halted       = (state_r == DONE);
    assign timeout      = (state_r == TIMEOUT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
//----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench: each driven cycle's expected outputs come from a
// behavioural model and are queued; a monitor pops and compares them on
// the falling edge. CYCLE_LIMIT is 20 so the watchdog is reached often.
//----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int LIMIT = 20;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       id_halt;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       ex_regwrite;
        logic       ex_memread;
        logic [4:0] ex_dst;
        logic [4:0] mem_dst;
        logic [4:0] wb_dst;
        logic       mem_regwrite;
        logic       wb_regwrite;
        logic       mem_redirect;
    } stim_t;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        f_ifid;
        logic        f_idex;
        logic        f_exmem;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  st;
        logic [3:0]  sv;
        logic [31:0] cnt;
        logic        halted;
        logic        timeout;
    } exp_t;

    logic        clk;
    stim_t       s_cur;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [3:0]  stage_valid;
    logic [31:0] cycle_count;
    logic        halted, timeout;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: pipeline occupancy as an array, halt as a stage index.
    int   ms;          // 0 RUN, 1 DRAIN, 2 DONE, 3 TIMEOUT
    bit   mv[4];       // 0 ID, 1 EX, 2 MEM, 3 WB
    int   mh;          // halt stage: 0 none, 1 EX, 2 MEM, 3 WB
    int   mc;
    bit   m_init = 1'b0;

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .CYCLE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(s_cur.rst),
        .id_rs(s_cur.id_rs), .id_rt(s_cur.id_rt),
        .id_uses_rs(s_cur.id_uses_rs), .id_uses_rt(s_cur.id_uses_rt),
        .id_halt(s_cur.id_halt),
        .ex_rs(s_cur.ex_rs), .ex_rt(s_cur.ex_rt),
        .ex_regwrite(s_cur.ex_regwrite), .ex_memread(s_cur.ex_memread),
        .ex_dst(s_cur.ex_dst), .mem_dst(s_cur.mem_dst), .wb_dst(s_cur.wb_dst),
        .mem_regwrite(s_cur.mem_regwrite), .wb_regwrite(s_cur.wb_regwrite),
        .mem_redirect(s_cur.mem_redirect),
        .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_valid(stage_valid), .state(state),
        .cycle_count(cycle_count), .halted(halted), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit reads_id(input logic [4:0] d);
        return (d != 5'd0) && ((s_cur.id_uses_rs && d == s_cur.id_rs) ||
                               (s_cur.id_uses_rt && d == s_cur.id_rt));
    endfunction

    function automatic int fwd_src(input logic [4:0] src);
        if (mv[2] && s_cur.mem_regwrite && s_cur.mem_dst != 5'd0 && s_cur.mem_dst == src) return 1;
        if (mv[3] && s_cur.wb_regwrite && s_cur.wb_dst != 5'd0 && s_cur.wb_dst == src) return 2;
        return 0;
    endfunction

    // Predict this cycle's outputs, then advance the model across the edge.
    task automatic model_cycle(output exp_t e, output bit have);
        bit running, redir, haz;
        int fa, fb;
        bit nv[4];
        have    = m_init;
        running = (ms == 0) || (ms == 1);
        e       = '0;
        e.sv      = {mv[3], mv[2], mv[1], mv[0]};
        e.st      = 2'(ms);
        e.cnt     = 32'(mc);
        e.halted  = (ms == 2);
        e.timeout = (ms == 3);
        redir = mv[2] && s_cur.mem_redirect && ((ms == 0) || (ms == 1 && (mh == 1 || mh == 2)));
`ifdef HAZARD_FORWARDING_EN
        haz = mv[0] && mv[1] && s_cur.ex_memread && reads_id(s_cur.ex_dst);
        fa  = fwd_src(s_cur.ex_rs);
        fb  = fwd_src(s_cur.ex_rt);
`else
        haz = mv[0] && ((mv[1] && s_cur.ex_regwrite && reads_id(s_cur.ex_dst)) ||
                        (mv[2] && s_cur.mem_regwrite && reads_id(s_cur.mem_dst)) ||
                        (mv[3] && s_cur.wb_regwrite && reads_id(s_cur.wb_dst)));
        fa  = 0;
        fb  = 0;
`endif
        haz = haz && (ms == 0);
        if (!running) begin fa = 0; fb = 0; end
        e.pc = 1'b1; e.ifid = 1'b1;
        if (!running) begin
            e.pc = 1'b0; e.ifid = 1'b0;
        end else if (redir) begin
            e.f_ifid = 1'b1; e.f_idex = 1'b1; e.f_exmem = 1'b1;
        end else if (ms == 1) begin
            e.pc = 1'b0; e.f_ifid = 1'b1;
        end else if (haz) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.f_idex = 1'b1;
        end
        e.fa = 2'(fa);
        e.fb = 2'(fb);
        if (s_cur.rst) begin
            e.pc = 1'b1; e.ifid = 1'b1; e.f_ifid = 1'b0; e.f_idex = 1'b0; e.f_exmem = 1'b0;
            e.fa = 2'b00; e.fb = 2'b00;
        end
        if (s_cur.rst) begin
            ms = 0; mh = 0; mc = 0; m_init = 1'b1;
            foreach (mv[i]) mv[i] = 1'b0;
        end else if (m_init && running) begin
            nv[3] = mv[2]; nv[2] = mv[1]; nv[1] = mv[0]; nv[0] = (ms == 0);
            if (redir) begin
                nv[0] = 1'b0; nv[1] = 1'b0; nv[2] = 1'b0; mh = 0; ms = 0;
            end else if (haz) begin
                nv[1] = 1'b0; nv[0] = mv[0];
            end else if (ms == 1) begin
                if (mh == 3) begin ms = 2; mh = 0; end
                else mh = mh + 1;
            end else if (mv[0] && s_cur.id_halt) begin
                ms = 1; mh = 1;
            end
            mv = nv;
            mc = mc + 1;
            if (mc >= LIMIT) ms = 3;
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit   have;
        @(posedge clk);
        #1;
        s_cur = s;
        model_cycle(e, have);
        if (have) q.push_back(e);
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst          = ($urandom_range(0, 39) == 0);
        s.id_rs        = 5'($urandom_range(0, 3));
        s.id_rt        = 5'($urandom_range(0, 3));
        s.id_uses_rs   = 1'($urandom);
        s.id_uses_rt   = 1'($urandom);
        s.id_halt      = ($urandom_range(0, 9) == 0);
        s.ex_rs        = 5'($urandom_range(0, 3));
        s.ex_rt        = 5'($urandom_range(0, 3));
        s.ex_regwrite  = 1'($urandom);
        s.ex_memread   = 1'($urandom);
        s.ex_dst       = 5'($urandom_range(0, 3));
        s.mem_dst      = 5'($urandom_range(0, 3));
        s.wb_dst       = 5'($urandom_range(0, 3));
        s.mem_regwrite = 1'($urandom);
        s.wb_regwrite  = 1'($urandom);
        s.mem_redirect = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_en",        32'(pc_en),        32'(e.pc));
                chk("if_id_en",     32'(if_id_en),     32'(e.ifid));
                chk("if_id_flush",  32'(if_id_flush),  32'(e.f_ifid));
                chk("id_ex_flush",  32'(id_ex_flush),  32'(e.f_idex));
                chk("ex_mem_flush", 32'(ex_mem_flush), 32'(e.f_exmem));
                chk("fwd_a",        32'(fwd_a),        32'(e.fa));
                chk("fwd_b",        32'(fwd_b),        32'(e.fb));
                chk("stage_valid",  32'(stage_valid),  32'(e.sv));
                chk("state",        32'(state),        32'(e.st));
                chk("cycle_count",  cycle_count,       e.cnt);
                chk("halted",       32'(halted),       32'(e.halted));
                chk("timeout",      32'(timeout),      32'(e.timeout));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic do_reset();
        stim_t s;
        s = nop();
        s.rst = 1'b1;
        step(s);
    endtask

    initial begin
        stim_t s;
        s_cur = nop();
        s_cur.rst = 1'b1;
        do_reset();
        do_reset();

        // Dependent add: writer walks EX -> MEM -> WB while ID reads $7.
        repeat (4) step(nop());
        s = nop(); s.id_rs = 5'd7; s.id_uses_rs = 1'b1; s.ex_regwrite = 1'b1; s.ex_dst = 5'd7; step(s);
        s = nop(); s.id_rs = 5'd7; s.id_uses_rs = 1'b1; s.mem_regwrite = 1'b1; s.mem_dst = 5'd7; s.ex_rs = 5'd7; step(s);
        s = nop(); s.id_rs = 5'd7; s.id_uses_rs = 1'b1; s.wb_regwrite = 1'b1; s.wb_dst = 5'd7; s.ex_rs = 5'd7; step(s);
        s = nop(); s.id_rs = 5'd7; s.id_uses_rs = 1'b1; s.ex_rs = 5'd7; step(s);

        // Load-use on $5, then forwarding from WB.
        do_reset();
        repeat (4) step(nop());
        s = nop(); s.id_rt = 5'd5; s.id_uses_rt = 1'b1; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; s.ex_dst = 5'd5; step(s);
        s = nop(); s.id_rt = 5'd5; s.id_uses_rt = 1'b1; s.mem_regwrite = 1'b1; s.mem_dst = 5'd5; step(s);
        s = nop(); s.ex_rt = 5'd5; s.wb_regwrite = 1'b1; s.wb_dst = 5'd5; step(s);

        // Redirect together with a load-use hazard.
        repeat (2) step(nop());
        s = nop(); s.id_rs = 5'd2; s.id_uses_rs = 1'b1; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
        s.ex_dst = 5'd2; s.mem_redirect = 1'b1; step(s);
        repeat (2) step(nop());

        // Halt, drain to DONE, stay frozen.
        do_reset();
        repeat (4) step(nop());
        s = nop(); s.id_halt = 1'b1; step(s);
        repeat (8) step(nop());

        // Watchdog with no halt, then reset back to RUN.
        do_reset();
        repeat (25) step(nop());
        do_reset();
        repeat (2) step(nop());

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < int'($urandom_range(5, 28)); c++) step(rand_stim());
        end

        step(nop());
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_AW, default 5, register-address width; CNT_W, default 32, cycle-counter width; CYCLE_LIMIT, default 10000, protection cycle limit.
REQ-002 Ports SHALL be:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_rs, id_rt  in  REG_AW  ID-stage source registers.
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt.
- id_halt  in  1  ID instruction equals 32'hFFFFFFFF.
- ex_rs, ex_rt  in  REG_AW  EX-stage source registers.
- ex_regwrite, ex_memread  in  1  EX control bits.
- ex_dst, mem_dst, wb_dst  in  REG_AW  destination registers.
- mem_regwrite, wb_regwrite  in  1  write enables.
- mem_redirect  in  1  taken branch or jump resolved in MEM.
- pc_en, if_id_en  out  1  PC and IF/ID load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble next edge.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM ALU result, 10 WB value.
- stage_valid  out  4  valid bits {WB,MEM,EX,ID}.
- state  out  2  controller state.
- cycle_count  out  CNT_W  cycles since reset.
- halted, timeout  out  1  terminal-state flags.

Function
REQ-003 States SHALL be RUN=0, DRAIN=1, DONE=2, TIMEOUT=3.
REQ-004 Hazard comparisons SHALL be gated by internal stage_valid bits; a register-0 destination SHALL never match.
REQ-005 Load-use: EX valid, ex_memread, ex_dst matching a used ID source -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle.
REQ-006 mem_redirect with MEM valid SHALL assert if_id_flush, id_ex_flush, ex_mem_flush and pc_en=1 in the same cycle, and clear ID/EX/MEM valid at the next edge.
REQ-007 Redirect SHALL take priority over load-use stall; both asserted -> redirect behaviour only.
REQ-008 Forwarding: fwd_a=01 when MEM valid, mem_regwrite, mem_dst==ex_rs; else 10 when WB valid, wb_regwrite, wb_dst==ex_rs; else 00; fwd_b identical against ex_rt.
REQ-009 Valid bits SHALL shift ID->EX->MEM->WB each non-terminal cycle; a bubble inserts 0.
REQ-010 RUN->DRAIN when ID valid, id_halt, no stall, no redirect; in DRAIN pc_en=0, if_id_flush=1, and a 3-bit halt marker tracks the halt instruction to WB.
REQ-011 DRAIN->DONE the cycle after the halt marker reaches WB; DONE: halted=1, all enables 0, all flushes 0.
REQ-012 DRAIN->RUN on mem_redirect while the halt marker is in ID/EX/EX/MEM (wrong path); marker cleared, redirect applied.
REQ-013 cycle_count SHALL increment in RUN and DRAIN, freeze in DONE and TIMEOUT.
REQ-014 cycle_count reaching CYCLE_LIMIT in RUN/DRAIN SHALL enter TIMEOUT: timeout=1, enables 0; takes priority over DRAIN->DONE in the same cycle.
REQ-015 DONE and TIMEOUT SHALL be exited only by rst.

Reset
REQ-016 rst SHALL set state=RUN, stage_valid=0000, cycle_count=0, halted=0, timeout=0, marker=0.
REQ-017 During and the cycle after rst: pc_en=1, if_id_en=1, flushes 0, fwd_a=fwd_b=00.
REQ-018 rst mid-DRAIN or in terminal states SHALL return to RUN at the same edge.

Configuration
REQ-019 Macro HAZARD_FORWARDING_EN: defined -> REQ-005/REQ-008 as written.
REQ-020 Undefined -> fwd_a=fwd_b=00 constantly; stall (pc_en=0, if_id_en=0, id_ex_flush=1) while any valid EX/MEM/WB stage with regwrite has dst matching a used ID source.

Verification
REQ-021 add $3 in EX, ID uses $3 (forwarding on) -> no stall, next cycle fwd_a=01; one cycle later fwd_a=10.
REQ-022 lw $5 in EX, ID uses $5 -> one cycle pc_en=0, id_ex_flush=1; following cycle fwd=10 for $5.
REQ-023 mem_redirect with simultaneous load-use -> three flushes, pc_en=1, stage_valid{ID,EX,MEM}=000 next.
REQ-024 id_halt in RUN -> DRAIN; halted=1 exactly 4 cycles later; cycle_count frozen thereafter.
REQ-025 CYCLE_LIMIT=20, no halt -> timeout=1 at count 20, state=3, rst returns RUN with count 0.
REQ-026 Macro undefined, add $7 then dependent use -> 3 stall cycles, fwd_a stays 00.
